regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined RISC-V core; next generation of the 2R/1W register file.
- Configurable width, depth, read-port count and write-port count. Same-cycle internal forwarding across all write ports.
- Adds a per-register pending scoreboard: decode marks a destination busy at issue, writeback clears it. Hazard/stall logic reads the busy flags directly.
- Sits between decode (reads, allocates) and writeback (writes).

Parameters:
REG_WIDTH, 32, data width of each register
NUM_REGS, 32, number of entries; must be a power of two, at least 2; entry 0 is hard zero
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports; a higher index has higher priority
AW, $clog2(NUM_REGS), address width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset_b  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW]
rd_dout  out  NUM_RD*REG_WIDTH  read data, combinational
rd_busy  out  NUM_RD  read register has a pending producer not satisfied this cycle
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR*AW  write addresses
wr_din  in  NUM_WR*REG_WIDTH  write data
alloc_en  in  1  mark alloc_addr pending (instruction issued with a destination)
alloc_addr  in  AW  destination being allocated
flush  in  1  synchronous clear of all pending bits (pipeline flush)
pending_cnt  out  AW+1  number of entries currently pending, registered

Behaviour:
- Reset (reset_b low, asynchronous):
  - all entries = 0
  - all pending bits = 0
  - pending_cnt = 0
  - rd_busy = 0 for all ports (after reset the outputs are combinational from cleared state)
- Writes:
  - On posedge clk, each port with wr_en=1 and wr_addr!=0 writes wr_din.
  - Same-address collision: the highest-index enabled port wins.
  - Writes to entry 0 are ignored.
- Reads (combinational, zero latency), per read port i:
  - addr==0 -> rd_dout = 0.
  - else if any enabled write port targets addr -> rd_dout = wr_din of the highest-index matching port (internal forwarding).
  - else -> stored value.
- Pending scoreboard, one bit per entry; bit 0 is constant 0.
  - Next-state per entry e, in this priority order:
    1. flush -> 0
    2. alloc_en && alloc_addr==e && e!=0 -> 1
    3. any wr_en with wr_addr==e -> 0
    4. otherwise hold
  - A simultaneous alloc and write to the same entry leaves it pending: the new producer is younger than the writeback.
  - flush beats a same-cycle alloc. Register data writes still occur during flush.
- rd_busy[i] = pending[addr] && !(any enabled write to addr this cycle) && addr!=0.
  - rd_busy ignores the same-cycle alloc, so an instruction never stalls on itself.
- pending_cnt: registered popcount of the next-state pending vector. It updates on the same edge as the pending bits. Maximum value NUM_REGS-1.
- No handshake back-pressure:
  - alloc on an already-pending entry is legal; it stays 1 (WAW; the newest writer clears it).
  - A write to a non-pending entry is legal and leaves it 0.
- Reset asserted mid-operation clears state immediately. Stores and allocs on the edge coinciding with reset release are not required to take effect.
- Widths are exact: no sign extension; the address compare uses the full AW bits.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants REG_WIDTH_D=32, NUM_REGS_D=32
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [31:0])
  - the function fwd_select, which returns the highest-index matching write port
- One natural sub-module: regfile_scoreboard. It holds the pending bits, the next-state logic and pending_cnt, and exports pending vector and wr_hit vector. regfile_mp instantiates it and keeps the data array and read muxes.

Test Plan:
1. Reset then read:
   - Stimulus: preload via writes x5=0xDEADBEEF, x0=0x1234; read rd_addr[0]=5, rd_addr[1]=0.
   - Response: 0xDEADBEEF, 0x00000000; x0 is never written.
2. Forwarding with NUM_WR=2:
   - Stimulus: one cycle with port0 writing x7=0x11 and port1 writing x7=0x22; read x7 in that cycle.
   - Response: rd_dout=0x22 in that cycle; the stored value is 0x22 next cycle.
3. Scoreboard life cycle:
   - Stimulus: alloc x3; next cycle read x3; later write x3=0x55 and read x3 in the same cycle.
   - Response: after alloc, rd_busy=1 and pending_cnt=1. On the write cycle, rd_busy=0 and rd_dout=0x55. After the write, pending_cnt=0.
4. Alloc and write same entry, same cycle:
   - Stimulus: x9 pending; alloc x9 and write x9 together.
   - Response: x9 remains pending; pending_cnt unchanged; a read of x9 that cycle forwards the data with rd_busy=0.
5. Flush:
   - Stimulus: alloc x1, x2, x4 over three cycles (pending_cnt=3); then flush together with alloc x6.
   - Response: all pending bits 0 and pending_cnt=0 next cycle; x6 not pending.
6. Async reset mid-stream:
   - Stimulus: pending_cnt=2, x8=0xAA; pulse reset_b low between clock edges.
   - Response: immediately x8 reads 0, all rd_busy=0, pending_cnt=0 with no clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the forwarding-priority helper for the
// multi-port register file.
package regfile_pkg;

    localparam int REG_WIDTH_D  = 32;
    localparam int NUM_REGS_D   = 32;

    // Upper bound on write ports that fwd_select can arbitrate between.
    localparam int MAX_WR_PORTS = 8;
    localparam int SEL_W        = $clog2(MAX_WR_PORTS);

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    // Highest-index set bit wins, matching write-port priority.
    function automatic logic [SEL_W-1:0] fwd_select(input logic [MAX_WR_PORTS-1:0] hits);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < MAX_WR_PORTS; i++) begin
            if (hits[i]) begin
                sel = SEL_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register, set at issue and
// cleared by writeback or a pipeline flush, plus a registered popcount.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int NUM_WR   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic                 flush,
    output logic [NUM_REGS-1:0]  pending,
    output logic [NUM_REGS-1:0]  wr_hit,
    output logic [AW:0]          pending_cnt
);

    logic [NUM_REGS-1:0] pending_next;
    logic [AW:0]         cnt_next;

    always_comb begin
        wr_hit = '0;
        for (int e = 0; e < NUM_REGS; e++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(e))) begin
                    wr_hit[e] = 1'b1;
                end
            end
        end
    end

    // Alloc outranks a same-cycle writeback: the newly issued producer is younger.
    always_comb begin
        pending_next = pending;
        for (int e = 1; e < NUM_REGS; e++) begin
            if (flush) begin
                pending_next[e] = 1'b0;
            end else if (alloc_en && (alloc_addr == AW'(e))) begin
                pending_next[e] = 1'b1;
            end else if (wr_hit[e]) begin
                pending_next[e] = 1'b0;
            end
        end
        pending_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int e = 0; e < NUM_REGS; e++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, pending_next[e]};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_next;
            pending_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write forwarding and a pending
// scoreboard feeding the hazard logic. Entry 0 always reads as zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH = REG_WIDTH_D,
    parameter int NUM_REGS  = NUM_REGS_D,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int AW        = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        reset_b,
    input  logic [NUM_RD*AW-1:0]        rd_addr,
    output logic [NUM_RD*REG_WIDTH-1:0] rd_dout,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AW-1:0]        wr_addr,
    input  logic [NUM_WR*REG_WIDTH-1:0] wr_din,
    input  logic                        alloc_en,
    input  logic [AW-1:0]               alloc_addr,
    input  logic                        flush,
    output logic [AW:0]                 pending_cnt
);

    logic [REG_WIDTH-1:0]    mem [NUM_REGS];
    logic [NUM_REGS-1:0]     pending;
    logic [NUM_REGS-1:0]     wr_hit;
    logic [AW-1:0]           rd_a;
    logic [MAX_WR_PORTS-1:0] rd_hits;
    logic [SEL_W-1:0]        rd_sel;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .AW       (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset_b     (reset_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .pending     (pending),
        .wr_hit      (wr_hit),
        .pending_cnt (pending_cnt)
    );

    // Ports are visited in ascending order so the highest-index write lands last.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int e = 0; e < NUM_REGS; e++) begin
                mem[e] <= '0;
            end
        end else begin
            for (int e = 1; e < NUM_REGS; e++) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(e))) begin
                        mem[e] <= wr_din[w*REG_WIDTH +: REG_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_dout = '0;
        rd_busy = '0;
        rd_a    = '0;
        rd_hits = '0;
        rd_sel  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a    = rd_addr[i*AW +: AW];
            rd_hits = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                rd_hits[w] = wr_en[w] && (wr_addr[w*AW +: AW] == rd_a);
            end
            rd_sel = fwd_select(rd_hits);
            if (rd_a != '0) begin
                if (|rd_hits) begin
                    rd_dout[i*REG_WIDTH +: REG_WIDTH] = wr_din[int'(rd_sel)*REG_WIDTH +: REG_WIDTH];
                end else begin
                    rd_dout[i*REG_WIDTH +: REG_WIDTH] = mem[rd_a];
                end
                rd_busy[i] = pending[rd_a] && !wr_hit[rd_a];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then random traffic,
// checked against an array-based reference model.
module tb_regfile_mp;

    localparam int W     = 32;
    localparam int NREGS = 16;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 4;

    typedef struct packed {
        logic [NWR-1:0]          wr_en;
        logic [NWR-1:0][AW-1:0]  wa;
        logic [NWR-1:0][W-1:0]   wd;
        logic [NRD-1:0][AW-1:0]  ra;
        logic                    alloc_en;
        logic [AW-1:0]           aa;
        logic                    flush;
    } stim_t;

    typedef struct packed {
        logic [NRD-1:0][W-1:0] dout;
        logic [NRD-1:0]        busy;
        logic [AW:0]           cnt;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_b;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*W-1:0]     rd_dout;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*W-1:0]     wr_din;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic                 flush;
    logic [AW:0]          pending_cnt;

    logic [W-1:0] m_mem  [NREGS];
    bit           m_pend [NREGS];

    exp_t  exp_q[$];
    string name_q[$];
    event  sample_ev;
    int    checks = 0;
    int    errors = 0;

    regfile_mp #(
        .REG_WIDTH (W),
        .NUM_REGS  (NREGS),
        .NUM_RD    (NRD),
        .NUM_WR    (NWR)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .rd_addr     (rd_addr),
        .rd_dout     (rd_dout),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_din      (wr_din),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Expected outputs for the current cycle, from the model state before the edge.
    function automatic exp_t predict(stim_t s);
        exp_t e;
        e = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (m_pend[r]) e.cnt = e.cnt + 1'b1;
        end
        for (int i = 0; i < NRD; i++) begin
            logic [W-1:0] d;
            bit fw;
            d  = m_mem[s.ra[i]];
            fw = 0;
            for (int w = 0; w < NWR; w++) begin
                if (s.wr_en[w] && s.wa[w] == s.ra[i]) begin
                    d  = s.wd[w];
                    fw = 1;
                end
            end
            if (s.ra[i] == '0) d = '0;
            e.dout[i] = d;
            e.busy[i] = (s.ra[i] != '0) && m_pend[s.ra[i]] && !fw;
        end
        return e;
    endfunction

    task automatic driveInputs(input stim_t s);
        wr_en      = s.wr_en;
        wr_addr    = s.wa;
        wr_din     = s.wd;
        rd_addr    = s.ra;
        alloc_en   = s.alloc_en;
        alloc_addr = s.aa;
        flush      = s.flush;
    endtask

    task automatic applyStimulus(input stim_t s, input string name);
        driveInputs(s);
        exp_q.push_back(predict(s));
        name_q.push_back(name);
        @(posedge clk);
        for (int w = 0; w < NWR; w++) begin
            if (s.wr_en[w] && s.wa[w] != '0) m_mem[s.wa[w]] = s.wd[w];
        end
        for (int w = 0; w < NWR; w++) begin
            if (s.wr_en[w]) m_pend[s.wa[w]] = 0;
        end
        if (s.alloc_en && s.aa != '0) m_pend[s.aa] = 1;
        if (s.flush) begin
            for (int r = 0; r < NREGS; r++) m_pend[r] = 0;
        end
        #1;
    endtask

    // Call just after a rising edge; the reset pulse ends before the next falling edge.
    task automatic resetPulse(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input string name);
        stim_t s;
        s = idle_stim();
        s.ra[0] = ra0;
        s.ra[1] = ra1;
        driveInputs(s);
        reset_b = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 0;
        end
        #1;
        exp_q.push_back(predict(s));
        name_q.push_back(name);
        ->sample_ev;
        #1;
        reset_b = 1'b1;
    endtask

    task automatic checkOutput(input exp_t e, input exp_t a, input string name);
        for (int i = 0; i < NRD; i++) begin
            checks++;
            if (a.dout[i] !== e.dout[i]) begin
                errors++;
                $display("[TB] FAIL %s rd_dout[%0d]: got %h expected %h", name, i, a.dout[i], e.dout[i]);
            end
        end
        checks++;
        if (a.busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL %s rd_busy: got %b expected %b", name, a.busy, e.busy);
        end
        checks++;
        if (a.cnt !== e.cnt) begin
            errors++;
            $display("[TB] FAIL %s pending_cnt: got %0d expected %0d", name, a.cnt, e.cnt);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string n;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                n    = name_q.pop_front();
                a.dout = rd_dout;
                a.busy = rd_busy;
                a.cnt  = pending_cnt;
                checkOutput(e, a, n);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        stim_t s;
        reset_b = 1'b0;
        driveInputs(idle_stim());
        repeat (2) @(posedge clk);
        #1;
        resetPulse(4'd5, 4'd0, "reset_state");

        // Preload x5 and attempt a write to x0, then read both back.
        s = idle_stim();
        s.wr_en = 2'b11; s.wa[0] = 4'd5; s.wd[0] = 32'hDEADBEEF;
        s.wa[1] = 4'd0; s.wd[1] = 32'h1234;
        s.ra[0] = 4'd5; s.ra[1] = 4'd0;
        applyStimulus(s, "preload_fwd");
        s.wr_en = '0;
        applyStimulus(s, "preload_read");

        // Both write ports hit x7; port 1 must win.
        s = idle_stim();
        s.wr_en = 2'b11; s.wa[0] = 4'd7; s.wd[0] = 32'h11; s.wa[1] = 4'd7; s.wd[1] = 32'h22;
        s.ra[0] = 4'd7; s.ra[1] = 4'd7;
        applyStimulus(s, "collide_fwd");
        s.wr_en = '0;
        applyStimulus(s, "collide_store");

        // Scoreboard life cycle on x3.
        s = idle_stim();
        s.alloc_en = 1'b1; s.aa = 4'd3; s.ra[0] = 4'd3;
        applyStimulus(s, "alloc_x3");
        s = idle_stim(); s.ra[0] = 4'd3;
        applyStimulus(s, "x3_busy");
        s.wr_en = 2'b01; s.wa[0] = 4'd3; s.wd[0] = 32'h55;
        applyStimulus(s, "x3_writeback");
        s = idle_stim(); s.ra[0] = 4'd3;
        applyStimulus(s, "x3_cleared");

        // Alloc and write the same entry in one cycle.
        s = idle_stim(); s.alloc_en = 1'b1; s.aa = 4'd9;
        applyStimulus(s, "alloc_x9");
        s = idle_stim();
        s.alloc_en = 1'b1; s.aa = 4'd9;
        s.wr_en = 2'b10; s.wa[1] = 4'd9; s.wd[1] = 32'h99; s.ra[1] = 4'd9;
        applyStimulus(s, "x9_alloc_and_write");
        s = idle_stim(); s.ra[1] = 4'd9;
        applyStimulus(s, "x9_still_pending");
        s.wr_en = 2'b01; s.wa[0] = 4'd9; s.wd[0] = 32'h9A;
        applyStimulus(s, "x9_release");

        // Flush beats a same-cycle alloc.
        foreach (s.ra[i]) s.ra[i] = '0;
        s = idle_stim(); s.alloc_en = 1'b1;
        s.aa = 4'd1; applyStimulus(s, "alloc_x1");
        s.aa = 4'd2; applyStimulus(s, "alloc_x2");
        s.aa = 4'd4; applyStimulus(s, "alloc_x4");
        s.aa = 4'd6; s.flush = 1'b1; s.ra[0] = 4'd4; s.ra[1] = 4'd6;
        applyStimulus(s, "flush_with_alloc");
        s.alloc_en = 1'b0; s.flush = 1'b0;
        applyStimulus(s, "after_flush");

        // Asynchronous reset between edges with live state.
        s = idle_stim();
        s.wr_en = 2'b01; s.wa[0] = 4'd8; s.wd[0] = 32'hAA;
        applyStimulus(s, "write_x8");
        s = idle_stim(); s.alloc_en = 1'b1; s.aa = 4'd8;
        applyStimulus(s, "alloc_x8");
        s.aa = 4'd10;
        applyStimulus(s, "alloc_x10");
        s = idle_stim(); s.ra[0] = 4'd8; s.ra[1] = 4'd10;
        applyStimulus(s, "pre_reset_read");
        resetPulse(4'd8, 4'd10, "async_reset");

        for (int n = 0; n < 400; n++) begin
            s = idle_stim();
            s.wr_en = NWR'($urandom_range(0, 3));
            for (int w = 0; w < NWR; w++) begin
                s.wa[w] = AW'($urandom_range(0, NREGS - 1));
                s.wd[w] = $urandom;
            end
            s.alloc_en = ($urandom_range(0, 2) == 0);
            s.aa       = AW'($urandom_range(0, NREGS - 1));
            s.flush    = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NRD; i++) begin
                case ($urandom_range(0, 3))
                    0:       s.ra[i] = s.wa[$urandom_range(0, NWR - 1)];
                    1:       s.ra[i] = s.aa;
                    default: s.ra[i] = AW'($urandom_range(0, NREGS - 1));
                endcase
            end
            applyStimulus(s, "random");
            if (n == 200) begin
                resetPulse(AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)), "random_reset");
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
